alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle arithmetic/logic unit for the 8-bit CPU datapath, sitting directly downstream of the register file. It consumes the register file's fixed operand outputs (register 001 = operand A, register 010 = operand B). It computes the selected operation, single-cycle or 8-step iterative. It writes the result back to the result register (011) through the register file's save port. A start/busy/done handshake lets the control unit sequence ALU instructions.

## Interface
Parameters:
- RESULTREG, 3'b011, register index driven on saveselector during writeback

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; reset == 0 at a rising edge clears all state
- start  in  1  request; sampled only in IDLE
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV
- operanda  in  8  from register file aluoperandA
- operandb  in  8  from register file aluoperandB
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, coincident with writeback
- result  out  8  last computed result, held until next completion
- zero, carry, negative, overflow  out  1 each  flags of last completed op, held
- save  out  1  register file write enable, high only during WRITE
- saveselector  out  3  constant RESULTREG
- savebus  out  8  equals result

## Operation
- States: IDLE, EXEC, ITER, WRITE.
- IDLE with start=1 at an edge:
  - latch operanda, operandb, opcode into internal registers
  - go to ITER (MUL/DIV, step counter = 0) or EXEC (all others)
  - later operand changes have no effect.
- IDLE with start=0: remain in IDLE.
- EXEC: one edge computes the result and flags into the output registers, then WRITE.
- ITER: one shift-add (MUL) or restoring-subtract (DIV) step per edge.
  - After step 7 (8th edge) load result and flags, then go to WRITE.
- WRITE: save=1, done=1 for exactly one cycle; the next edge returns to IDLE.
  - start in WRITE is ignored.
- start while busy is ignored, not queued.
- Arithmetic, 8-bit results, flags:
  - ADD: A+B mod 256. carry = bit 8. overflow = signed overflow.
  - SUB: A−B mod 256. carry = borrow (A<B unsigned). overflow = signed overflow.
  - AND/OR/XOR: bitwise. carry = 0, overflow = 0.
  - SHL: A<<1. carry = A[7]. overflow = 0.
  - MUL: low byte of the unsigned 16-bit product. carry = high byte ≠ 0. overflow = 0.
  - DIV: unsigned quotient A/B. carry = 0, overflow = 0.
  - DIV with B=0: result 0xFF, carry=1, still takes the full 8 ITER cycles.
  - zero = (result == 0) for every op. negative = result[7] for every op.
- Reset values: IDLE, busy=0, done=0, save=0, result=0x00, all flags 0, internal operand/step registers 0. saveselector is always RESULTREG.

## Timing
- Start edge = E0.
- Single-cycle ops: result/flags registered at E1; save=done=1 during cycle E1→E2; register file commits at E2; busy high E0→E2.
- MUL/DIV: result registered at E8; save=done=1 during E8→E9; IDLE after E9.
- New start accepted back-to-back at the edge that leaves WRITE only if already in IDLE. Earliest new start sampled at E2 (single) or E9 (iterative).
- Reset low at any edge, including mid-ITER or during WRITE: immediately IDLE with reset values. No save pulse is issued for the aborted op. Result/flags are cleared, not retained.
- Reset has priority over start at the same edge.

## Test plan
- Reset held low for 2 edges, then released → busy=0, done=0, save=0, result=0x00, flags 0, saveselector=3'b011.
- ADD A=0x7F, B=0x01 → result 0x80, negative=1, overflow=1, carry=0, zero=0. done/save high exactly one cycle after E1. savebus=0x80.
- SUB A=0x03, B=0x05 → result 0xFE, carry=1, negative=1.
  - Then XOR A=0x5A, B=0x5A → result 0x00, zero=1, carry=0.
- MUL A=0x0D, B=0x0B → result 0x8F, carry=0, done at E8→E9.
  - Then MUL 0x20×0x10 → 0x00, zero=1, carry=1.
- DIV A=0x64, B=0x07 → result 0x0E after 8 ITER cycles.
  - Then DIV A=0x12, B=0x00 → 0xFF, carry=1.
  - Also pulse start with ADD mid-DIV → ignored, DIV result unaffected.
- Start MUL, drive reset low at E4 → next cycle busy=0, save never asserted, result=0x00.
  - Then ADD 0x01+0x02 completes normally with 0x03.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle 8-bit ALU between the register file operand
// outputs and its save port. Single-cycle ops take EXEC; MUL/DIV iterate
// eight ITER steps (shift-add / restoring divide). Results are written back
// to RESULTREG with a one-cycle save/done pulse in WRITE.
module alu_sequencer #(
  parameter logic [2:0] RESULTREG = 3'b011
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [7:0] operanda,
  input  logic [7:0] operandb,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       zero,
  output logic       carry,
  output logic       negative,
  output logic       overflow,
  output logic       save,
  output logic [2:0] saveselector,
  output logic [7:0] savebus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_ITER  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q;
  logic [7:0]  opa_q, opb_q;
  logic [2:0]  step_q;
  logic [15:0] acc_q, acc_d;     // MUL partial product
  logic [7:0]  rem_q, rem_d;     // DIV partial remainder
  logic [7:0]  quo_q, quo_d;     // DIV quotient bits shifted in MSB first
  logic [7:0]  result_q;
  logic [3:0]  flags_q;          // {zero, carry, negative, overflow}

  logic [7:0]  alu_res;
  logic        alu_c, alu_v;
  logic [8:0]  wide;
  logic [8:0]  rem_shift;
  logic [7:0]  next_res;
  logic        next_c, next_v;

  // Single-cycle datapath: result, carry and overflow for the latched op.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    case (op_q)
      OP_ADD: begin
        wide    = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res = wide[7:0];
        alu_c   = wide[8];
        alu_v   = (opa_q[7] == opb_q[7]) && (wide[7] != opa_q[7]);
      end
      OP_SUB: begin
        wide    = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res = wide[7:0];
        alu_c   = wide[8];
        alu_v   = (opa_q[7] != opb_q[7]) && (wide[7] != opa_q[7]);
      end
      OP_AND: alu_res = opa_q & opb_q;
      OP_OR:  alu_res = opa_q | opb_q;
      OP_XOR: alu_res = opa_q ^ opb_q;
      OP_SHL: begin
        alu_res = {opa_q[6:0], 1'b0};
        alu_c   = opa_q[7];
      end
      default: ;
    endcase
  end

  // One iteration step: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rem_shift = {rem_q, opa_q[3'd7 - step_q]};
    if (op_q == OP_MUL) begin
      if (opb_q[step_q]) acc_d = acc_q + ({8'h00, opa_q} << step_q);
    end else if (rem_shift >= {1'b0, opb_q}) begin
      rem_d = 8'(rem_shift - {1'b0, opb_q});
      quo_d = {quo_q[6:0], 1'b1};
    end else begin
      rem_d = rem_shift[7:0];
      quo_d = {quo_q[6:0], 1'b0};
    end
  end

  // Value to load into the output registers when the current op completes.
  always_comb begin
    next_res = alu_res;
    next_c   = alu_c;
    next_v   = alu_v;
    if (state_q == S_ITER) begin
      next_v = 1'b0;
      if (op_q == OP_MUL) begin
        next_res = acc_d[7:0];
        next_c   = acc_d[15:8] != 8'h00;
      end else begin
        next_res = quo_d;
        next_c   = opb_q == 8'h00;
      end
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (opcode[2:1] == 2'b11) ? S_ITER : S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_ITER:  if (step_q == 3'd7) state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand latches, iteration registers and held results.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          op_q   <= opcode;
          opa_q  <= operanda;
          opb_q  <= operandb;
          step_q <= '0;
          acc_q  <= '0;
          rem_q  <= '0;
          quo_q  <= '0;
        end
        S_EXEC: begin
          result_q <= next_res;
          flags_q  <= {next_res == 8'h00, next_c, next_res[7], next_v};
        end
        S_ITER: begin
          step_q <= step_q + 3'd1;
          acc_q  <= acc_d;
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          if (step_q == 3'd7) begin
            result_q <= next_res;
            flags_q  <= {next_res == 8'h00, next_c, next_res[7], next_v};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_WRITE;
  assign save         = state_q == S_WRITE;
  assign saveselector = RESULTREG;
  assign result       = result_q;
  assign savebus      = result_q;
  assign {zero, carry, negative, overflow} = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random ops,
// compared against an arithmetic reference model.
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] opcode = '0;
  logic [7:0] operanda = '0, operandb = '0;
  logic       busy, done, zero, carry, negative, overflow, save;
  logic [7:0] result, savebus;
  logic [2:0] saveselector;

  int checks = 0;
  int failures = 0;

  alu_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .operanda(operanda), .operandb(operandb), .busy(busy), .done(done),
    .result(result), .zero(zero), .carry(carry), .negative(negative),
    .overflow(overflow), .save(save), .saveselector(saveselector),
    .savebus(savebus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {result, zero, carry, negative, overflow} from plain arithmetic.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia = a, ib = b, sa, sb, r, s;
    logic c = 1'b0, v = 1'b0;
    logic [7:0] res;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    case (op)
      3'd0: begin r = ia + ib; c = r > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      3'd1: begin r = ia - ib; c = ia < ib; s = sa - sb; v = (s > 127) || (s < -128); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: begin r = ia * 2; c = ia >= 128; end
      3'd6: begin r = ia * ib; c = r > 255; end
      default: begin
        if (ib == 0) begin r = 255; c = 1'b1; end
        else r = ia / ib;
      end
    endcase
    res = 8'(r & 255);
    return {res, res == 8'h00, c, res[7], v};
  endfunction

  // Issue one op, scramble inputs after the start edge, wait (bounded) for
  // done and check latency, result, flags and the writeback pulse.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit poke);
    logic [11:0] exp;
    int lat, n;
    exp = model(op, a, b);
    lat = (op >= 3'd6) ? 9 : 2;
    @(negedge clock);
    start = 1'b1; opcode = op; operanda = a; operandb = b;
    @(negedge clock);
    start = 1'b0; opcode = 3'($urandom); operanda = 8'($urandom); operandb = 8'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 20) begin
      if (poke && n == 3) begin start = 1'b1; opcode = 3'd0; end
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_result"}, 32'(result), 32'(exp[11:4]));
    check({tag, "_flags"}, 32'({zero, carry, negative, overflow}), 32'(exp[3:0]));
    check({tag, "_save"}, 32'(save), 32'd1);
    check({tag, "_savebus"}, 32'(savebus), 32'(exp[11:4]));
    check({tag, "_sel"}, 32'(saveselector), 32'd3);
    @(negedge clock);
    check({tag, "_done_low"}, 32'({done, save}), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_held"}, 32'(result), 32'(exp[11:4]));
  endtask

  initial begin
    int n;
    bit save_seen;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    // Reset held low for two edges.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ctrl", 32'({busy, done, save}), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_flags", 32'({zero, carry, negative, overflow}), 32'd0);
    check("rst_sel", 32'(saveselector), 32'd3);
    reset = 1'b1;

    // Idle with start low stays idle.
    repeat (3) @(negedge clock);
    check("idle_hold", 32'(busy), 32'd0);

    // Directed cases.
    run_op("add_ovf", 3'd0, 8'h7F, 8'h01, 1'b0);
    run_op("sub_brw", 3'd1, 8'h03, 8'h05, 1'b0);
    run_op("xor_zero", 3'd4, 8'h5A, 8'h5A, 1'b0);
    run_op("mul_small", 3'd6, 8'h0D, 8'h0B, 1'b0);
    run_op("mul_wrap", 3'd6, 8'h20, 8'h10, 1'b0);
    run_op("div", 3'd7, 8'h64, 8'h07, 1'b0);
    run_op("div_zero", 3'd7, 8'h12, 8'h00, 1'b0);
    run_op("div_poke", 3'd7, 8'hC8, 8'h0A, 1'b1);
    run_op("shl", 3'd5, 8'hC1, 8'h00, 1'b0);
    run_op("and", 3'd2, 8'hF0, 8'h3C, 1'b0);
    run_op("or", 3'd3, 8'h00, 8'h00, 1'b0);
    run_op("sub_sovf", 3'd1, 8'h80, 8'h01, 1'b0);

    // Reset asserted for edge E4 of a MUL aborts it without a save pulse.
    @(negedge clock);
    start = 1'b1; opcode = 3'd6; operanda = 8'hFF; operandb = 8'hFF;
    @(negedge clock);
    start = 1'b0;
    save_seen = 1'b0;
    for (n = 1; n < 4; n++) begin
      save_seen |= save;
      @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'h00);
    check("abort_flags", 32'({zero, carry, negative, overflow}), 32'd0);
    reset = 1'b1;
    repeat (10) begin
      save_seen |= save;
      @(negedge clock);
    end
    check("abort_nosave", 32'(save_seen), 32'd0);
    run_op("add_after", 3'd0, 8'h01, 8'h02, 1'b0);

    // Randomized ops, with some forced divide-by-zero.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      ra  = 8'($urandom);
      rb  = (i % 8 == 7) ? 8'h00 : 8'($urandom);
      run_op("rand", rop, ra, rb, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
